// File: rtl/match_scorer.sv
// match_scorer: two-player match score keeper with latched target, serve tracking and winner detection
//
// Ports:
//   clk           system clock, all state changes on posedge
//   rst           asynchronous active-high reset
//   target_score  requested match length, sampled and clamped only when start is seen
//   start         single-cycle pulse that begins (or restarts) a match
//   p1_point      single-cycle pulse, player 1 won a rally
//   p2_point      single-cycle pulse, player 2 won a rally
//   p1_score      player 1 points (registered)
//   p2_score      player 2 points (registered)
//   active_target target latched at start, clamped to [MIN_TARGET, MAX_TARGET]
//   playing       high while a match is in progress
//   game_over     high once a winner has been declared
//   winner        00 none, 01 player 1, 10 player 2
//   win_pulse     one-cycle strobe on the edge a winner is declared
//   serve_side    0 = player 1 serves, 1 = player 2 serves
//
// Build option: define WIN_BY_TWO_EN to require a two-point lead (deuce rule);
// scores may then run past the target and saturate at all-ones.
module match_scorer #(
   parameter int SCORE_W    = 6,
   parameter int MAX_TARGET = 20,
   parameter int MIN_TARGET = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [SCORE_W-1:0] target_score,
   input  logic               start,
   input  logic               p1_point,
   input  logic               p2_point,
   output logic [SCORE_W-1:0] p1_score,
   output logic [SCORE_W-1:0] p2_score,
   output logic [SCORE_W-1:0] active_target,
   output logic               playing,
   output logic               game_over,
   output logic [1:0]         winner,
   output logic               win_pulse,
   output logic               serve_side
);
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_PLAY = 2'd1;
   localparam logic [1:0] S_OVER = 2'd2;
   localparam logic [SCORE_W-1:0] SAT   = '1;
   localparam logic [SCORE_W-1:0] MIN_T = SCORE_W'(MIN_TARGET);
   localparam logic [SCORE_W-1:0] MAX_T = SCORE_W'(MAX_TARGET);
   logic [1:0]         r_state;
   logic [SCORE_W-1:0] r_p1;
   logic [SCORE_W-1:0] r_p2;
   logic [SCORE_W-1:0] r_target;
   logic [1:0]         r_winner;
   logic               r_win_pulse;
   logic               r_serve;
   logic [SCORE_W-1:0] w_clamped;
   logic [SCORE_W-1:0] w_p1_inc;
   logic [SCORE_W-1:0] w_p2_inc;
   logic               w_p1_only;
   logic               w_p2_only;
   logic               w_p1_win;
   logic               w_p2_win;
   assign w_clamped = (target_score < MIN_T) ? MIN_T : (target_score > MAX_T) ? MAX_T : target_score;
   // Simultaneous pulses are a let: neither "only" strobe fires.
   assign w_p1_only = (r_state == S_PLAY) && p1_point && !p2_point;
   assign w_p2_only = (r_state == S_PLAY) && p2_point && !p1_point;
   assign w_p1_inc  = (r_p1 == SAT) ? SAT : r_p1 + SCORE_W'(1);
   assign w_p2_inc  = (r_p2 == SAT) ? SAT : r_p2 + SCORE_W'(1);
`ifdef WIN_BY_TWO_EN
   // Lead compares are one bit wider so opponent+2 cannot wrap.
   logic w_both_sat;
   assign w_both_sat = (r_p1 == SAT) && (r_p2 == SAT);
   assign w_p1_win = w_both_sat ||
                     ((w_p1_inc >= r_target) && ({1'b0, w_p1_inc} >= {1'b0, r_p2} + (SCORE_W+1)'(2)));
   assign w_p2_win = w_both_sat ||
                     ((w_p2_inc >= r_target) && ({1'b0, w_p2_inc} >= {1'b0, r_p1} + (SCORE_W+1)'(2)));
`else
   assign w_p1_win = w_p1_inc >= r_target;
   assign w_p2_win = w_p2_inc >= r_target;
`endif
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_p1        <= '0;
         r_p2        <= '0;
         r_target    <= MIN_T;
         r_winner    <= 2'b00;
         r_win_pulse <= 1'b0;
         r_serve     <= 1'b0;
      end else if (start) begin
         r_state     <= S_PLAY;
         r_p1        <= '0;
         r_p2        <= '0;
         r_target    <= w_clamped;
         r_winner    <= 2'b00;
         r_win_pulse <= 1'b0;
         r_serve     <= 1'b0;
      end else begin
         r_win_pulse <= 1'b0;
         if (w_p1_only) begin
            r_p1    <= w_p1_inc;
            r_serve <= 1'b1;
            if (w_p1_win) begin
               r_state     <= S_OVER;
               r_winner    <= 2'b01;
               r_win_pulse <= 1'b1;
            end
         end else if (w_p2_only) begin
            r_p2    <= w_p2_inc;
            r_serve <= 1'b0;
            if (w_p2_win) begin
               r_state     <= S_OVER;
               r_winner    <= 2'b10;
               r_win_pulse <= 1'b1;
            end
         end
      end
   end
   assign p1_score      = r_p1;
   assign p2_score      = r_p2;
   assign active_target = r_target;
   assign playing       = r_state == S_PLAY;
   assign game_over     = r_state == S_OVER;
   assign winner        = r_winner;
   assign win_pulse     = r_win_pulse;
   assign serve_side    = r_serve;
endmodule

// File: tb/tb_match_scorer.sv
// tb_match_scorer: scoreboard bench for match_scorer against a rule-level match model
module tb_match_scorer;
   typedef struct packed {
      logic [5:0] p1;
      logic [5:0] p2;
      logic [5:0] tgt;
      logic       play;
      logic       over;
      logic [1:0] win;
      logic       pulse;
      logic       serve;
   } obs_t;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] target_score = '0;
   logic       start = 1'b0;
   logic       p1_point = 1'b0;
   logic       p2_point = 1'b0;
   logic [5:0] p1_score;
   logic [5:0] p2_score;
   logic [5:0] active_target;
   logic       playing;
   logic       game_over;
   logic [1:0] winner;
   logic       win_pulse;
   logic       serve_side;
   int checks = 0;
   int errors = 0;
   obs_t q[$];
   int m_p1 = 0, m_p2 = 0, m_tgt = 1;
   bit m_play = 0, m_over = 0, m_pulse = 0, m_serve = 0;
   int m_win = 0;
   match_scorer dut (
      .clk(clk), .rst(rst), .target_score(target_score), .start(start),
      .p1_point(p1_point), .p2_point(p2_point), .p1_score(p1_score), .p2_score(p2_score),
      .active_target(active_target), .playing(playing), .game_over(game_over),
      .winner(winner), .win_pulse(win_pulse), .serve_side(serve_side)
   );
   always #5 clk = ~clk;
   task automatic chk(input string n, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
      end
   endtask
   function automatic bit wins(input int me, input int opp, input bit both_sat);
`ifdef WIN_BY_TWO_EN
      return both_sat || (me >= m_tgt && me >= opp + 2);
`else
      return me >= m_tgt;
`endif
   endfunction
   task automatic model(input bit r, input bit s, input bit a, input bit b, input int t);
      bit both_sat;
      if (r) begin
         m_p1 = 0; m_p2 = 0; m_tgt = 1; m_play = 0; m_over = 0; m_win = 0; m_pulse = 0; m_serve = 0;
      end else if (s) begin
         m_p1 = 0; m_p2 = 0; m_tgt = t < 1 ? 1 : (t > 20 ? 20 : t);
         m_play = 1; m_over = 0; m_win = 0; m_pulse = 0; m_serve = 0;
      end else begin
         m_pulse = 0;
         if (m_play && a != b) begin
            both_sat = m_p1 == 63 && m_p2 == 63;
            if (a) begin
               m_p1 = m_p1 < 63 ? m_p1 + 1 : 63;
               m_serve = 1;
               if (wins(m_p1, m_p2, both_sat)) begin m_play = 0; m_over = 1; m_win = 1; m_pulse = 1; end
            end else begin
               m_p2 = m_p2 < 63 ? m_p2 + 1 : 63;
               m_serve = 0;
               if (wins(m_p2, m_p1, both_sat)) begin m_play = 0; m_over = 1; m_win = 2; m_pulse = 1; end
            end
         end
      end
   endtask
   function automatic obs_t expected();
      obs_t e;
      e.p1 = 6'(m_p1); e.p2 = 6'(m_p2); e.tgt = 6'(m_tgt);
      e.play = m_play; e.over = m_over; e.win = 2'(m_win); e.pulse = m_pulse; e.serve = m_serve;
      return e;
   endfunction
   task automatic cycle(input bit s, input bit a, input bit b, input int t, input bit r = 0);
      @(negedge clk);
      rst = r; start = s; p1_point = a; p2_point = b; target_score = 6'(t);
      model(r, s, a, b, t);
      q.push_back(expected());
   endtask
   task automatic idle(input int n = 1);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, int'(target_score));
   endtask
   task automatic async_reset();
      @(negedge clk);
      start = 0; p1_point = 0; p2_point = 0;
      model(1, 0, 0, 0, 0);
      q.push_back(expected());
      #2 rst = 1;
      #1;
      chk("async p1_score", p1_score, 0);
      chk("async p2_score", p2_score, 0);
      chk("async target", active_target, 1);
      chk("async playing", playing, 0);
      chk("async winner", winner, 0);
      chk("async serve", serve_side, 0);
   endtask
   initial begin
      obs_t e, a;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() != 0) begin
            e = q.pop_front();
            a = '{p1_score, p2_score, active_target, playing, game_over, winner, win_pulse, serve_side};
            chk("scores", int'({a.p1, a.p2, a.tgt}), int'({e.p1, e.p2, e.tgt}));
            chk("status", int'({a.play, a.over, a.win, a.pulse, a.serve}), int'({e.play, e.over, e.win, e.pulse, e.serve}));
         end
      end
   end
   initial begin
      cycle(0, 0, 0, 0, 1);
      cycle(0, 0, 0, 0, 1);
      idle(1);
      chk("reset target", active_target, 1);
      cycle(1, 0, 0, 5);
      for (int i = 0; i < 5; i++) begin cycle(0, 1, 0, 5); idle(2); end
      cycle(1, 0, 0, 5);
      for (int i = 0; i < 4; i++) begin cycle(0, 1, 0, 5); idle(2); end
      cycle(0, 1, 0, 5);
      idle(1);
      chk("win p1_score", p1_score, 5);
      chk("win pulse", win_pulse, 1);
      chk("win winner", winner, 1);
      chk("win playing", playing, 0);
      idle(1);
      chk("win pulse drop", win_pulse, 0);
      chk("win game_over", game_over, 1);
      cycle(1, 0, 0, 0);
      idle(1);
      chk("clamp low", active_target, 1);
      cycle(0, 0, 1, 0);
      idle(1);
      chk("p2 wins", winner, 2);
      cycle(1, 0, 0, 40);
      idle(1);
      chk("clamp high", active_target, 20);
      cycle(1, 0, 0, 10);
      cycle(0, 1, 0, 10); cycle(0, 1, 0, 10);
      cycle(0, 0, 1, 10); cycle(0, 0, 1, 10); cycle(0, 0, 1, 10);
      cycle(0, 1, 1, 10);
      idle(1);
      chk("let p1", p1_score, 2);
      chk("let p2", p2_score, 3);
      chk("let serve", serve_side, 0);
      cycle(0, 1, 0, 10);
      idle(1);
      chk("after let p1", p1_score, 3);
      chk("after let serve", serve_side, 1);
      cycle(1, 0, 0, 7);
      for (int i = 0; i < 4; i++) cycle(0, 1, 0, 7);
      cycle(0, 0, 1, 7);
      cycle(0, 0, 0, 2);
      idle(1);
      chk("mid target", active_target, 7);
      chk("mid playing", playing, 1);
      cycle(1, 1, 0, 2);
      idle(1);
      chk("restart p1", p1_score, 0);
      chk("restart target", active_target, 2);
      chk("restart playing", playing, 1);
      cycle(1, 0, 0, 9);
      cycle(0, 1, 0, 9); cycle(0, 0, 1, 9);
      async_reset();
      cycle(0, 1, 0, 9); cycle(0, 0, 1, 9);
      idle(1);
      chk("idle ignore p1", p1_score, 0);
      chk("idle ignore p2", p2_score, 0);
      cycle(1, 0, 0, 3);
      for (int i = 0; i < 3; i++) begin cycle(0, 1, 0, 3); cycle(0, 0, 1, 3); end
      cycle(0, 1, 0, 3); cycle(0, 1, 0, 3);
      idle(1);
      chk("deuce winner", winner, 1);
`ifdef WIN_BY_TWO_EN
      chk("deuce p1", p1_score, 5);
      chk("deuce p2", p2_score, 3);
`else
      chk("deuce p1", p1_score, 3);
      chk("deuce p2", p2_score, 2);
`endif
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 299) == 0) async_reset();
         else cycle($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
                    int'($urandom_range(0, 63)));
      end
      idle(3);
      @(posedge clk);
      #2;
      chk("queue drained", q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/match_scorer.md
Name: match_scorer

Overview:
- Consumes the match target produced by the score-setting front end (button-driven 0..20 value).
- Counts points for both players during a match and declares the winner when a player reaches the latched target.
- Sits between the ball/collision logic, which supplies point pulses, and the display and game-control logic, which consume the scores and the winner.

Parameters:
SCORE_W, 6, width of target and score values
MAX_TARGET, 20, upper clamp applied to the latched target
MIN_TARGET, 1, lower clamp applied to the latched target (a target of 0 is never used)

Ports:
clk  input  1  system clock, all state changes on posedge
rst  input  1  asynchronous, active-high reset
target_score  input  SCORE_W  requested match length from the score-setting block; may change at any time
start  input  1  single-cycle pulse; begins a new match
p1_point  input  1  single-cycle pulse; player 1 won a rally
p2_point  input  1  single-cycle pulse; player 2 won a rally
p1_score  output  SCORE_W  player 1 points, registered
p2_score  output  SCORE_W  player 2 points, registered
active_target  output  SCORE_W  target latched at start, after clamping
playing  output  1  high while state = PLAY
game_over  output  1  high while state = OVER
winner  output  2  00 none, 01 player 1, 10 player 2
win_pulse  output  1  one-cycle strobe on entry to OVER
serve_side  output  1  0 = player 1 serves, 1 = player 2 serves

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state = IDLE
  - p1_score = p2_score = 0
  - active_target = MIN_TARGET
  - winner = 00, win_pulse = 0, serve_side = 0
- State encoding: IDLE, PLAY, OVER. Outputs playing and game_over are decoded from the registered state.
- IDLE:
  - Point pulses are ignored.
  - start → PLAY. On the same edge: clear both scores, latch active_target = clamp(target_score, MIN_TARGET, MAX_TARGET), set serve_side = 0.
- PLAY:
  - Exactly one point pulse → that player's score increments on the next edge (latency 1).
  - serve_side becomes the side that lost the rally (p1_point sets serve_side = 1; p2_point sets serve_side = 0).
  - p1_point and p2_point asserted in the same cycle → treated as a let: no score change, serve_side unchanged.
  - Win check uses the next-score value, so the winning score, state = OVER, winner and win_pulse all appear on the same edge.
  - Win condition: the incremented score >= active_target.
  - start during PLAY → restart: scores cleared, target re-latched, winner = 00; the same-cycle point pulse is discarded.
  - target_score changes during PLAY have no effect.
- OVER:
  - Scores and winner hold; point pulses are ignored.
  - start → behaves exactly as start in IDLE: goes to PLAY, clears winner, clears scores, re-latches target.
- win_pulse is high for exactly one cycle per match end.
- Scores never exceed 2^SCORE_W−1. Increment saturates at all-ones, which is only reachable with the optional feature enabled.
- Reset asserted mid-match aborts to the IDLE reset values on the same cycle, with no clock edge required.

Optional Feature:
WIN_BY_TWO_EN
- Defined:
  - A player wins only when their score >= active_target AND their score >= opponent's score + 2 (deuce rule).
  - Scores may exceed active_target.
  - Scores saturate at 2^SCORE_W−1. If both players saturate, the next point pulse ends the match in favour of the scorer.
- Undefined:
  - First to reach active_target wins; scores never exceed active_target.
  - The comparison logic for the 2-point lead is not synthesised.

Test Plan:
- Reset then start with target_score=5; five p1_point pulses spaced 3 cycles apart → p1_score=5 on the cycle after the 5th pulse, with game_over=1, winner=01, win_pulse high exactly 1 cycle, playing=0.
- target_score=0, start → active_target=1; one p2_point → winner=10. target_score=40, start → active_target=20.
- In PLAY at p1=2, p2=3: p1_point and p2_point in the same cycle → scores unchanged, serve_side unchanged. Then p1_point alone → p1=3, serve_side=1.
- Mid-match (p1=4, p2=1, target=7): change target_score to 2 → no win, active_target stays 7. Pulse start → scores 0/0, active_target=2, playing=1.
- Assert rst asynchronously between clock edges during PLAY → all outputs at reset values before the next posedge. Point pulses in IDLE are ignored (scores stay 0).
- With WIN_BY_TWO_EN, target=3: p1 and p2 alternate to 3/3, then p1 point gives 4/3 with no win, then p1 point gives 5/3 with winner=01. Without the macro, the same sequence ends at p1=3 while p2=2.
